dcache_vc: RTL and testbench

Parametrised direct-mapped, write-back, no-write-allocate data cache with a fully-associative victim buffer of configurable depth.
- Serves one LSQ request at a time over a valid/ready request port and returns a tagged response.
- Owns its miss handling: line fill, forwarding of write misses, and write-back of dirty victims over a single valid/ready memory port.
- Sits between the LSQ and the memory arbiter.

---
 rtl/dcache_vc.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_dcache_vc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_vc.sv
// Direct-mapped write-back, no-write-allocate data cache with FIFO victim buffer.
// Define DCACHE_STATS_EN to add hit / victim-hit / miss counters.
`timescale 1ns/1ps
module dcache_vc #(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8,
    parameter int VC_DEPTH = 2,
    parameter int GNT_W    = 8,
    localparam int AW      = TAG_BITS + IDX_BITS + 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [1:0]       req_size,
    input  logic [63:0]      req_wdata,
    input  logic [GNT_W-1:0] req_gnt,
    output logic             rsp_valid,
    output logic [63:0]      rsp_data,
    output logic [GNT_W-1:0] rsp_gnt,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_wr,
    output logic [AW-1:0]    mem_req_addr,
    output logic [63:0]      mem_req_wdata,
    output logic [1:0]       mem_req_size,
    input  logic             mem_rsp_valid,
    input  logic [63:0]      mem_rsp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      vhit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    localparam int NL = 1 << IDX_BITS;
    localparam int LW = TAG_BITS + IDX_BITS;
    localparam int PW = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_FWD, S_FILL_REQ, S_FILL_WAIT, S_EVICT, S_RESP
    } state_e;

    state_e state_q;

    logic [63:0]         line_data_q [NL];
    logic [TAG_BITS-1:0] line_tag_q  [NL];
    logic [NL-1:0]       valid_q, dirty_q;
    logic [63:0]         vc_data_q [VC_DEPTH];
    logic [LW-1:0]       vc_line_q [VC_DEPTH];
    logic [VC_DEPTH-1:0] vc_valid_q, vc_dirty_q;
    logic [PW-1:0]       fifo_q;

    logic [IDX_BITS-1:0] r_idx_q;
    logic [TAG_BITS-1:0] r_tag_q;
    logic [2:0]          r_off_q;
    logic [1:0]          r_size_q;

    logic             req_ready_q, rsp_valid_q;
    logic [63:0]      rsp_data_q;
    logic [GNT_W-1:0] rsp_gnt_q;
    logic             mreq_valid_q, mreq_wr_q;
    logic [AW-1:0]    mreq_addr_q;
    logic [63:0]      mreq_wdata_q;
    logic [1:0]       mreq_size_q;

    function automatic logic [63:0] size_mask(input logic [1:0] s);
        logic [63:0] m;
        unique case (s)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] line,
                                            input logic [2:0] off,
                                            input logic [1:0] s);
        return (line >> {off, 3'b000}) & size_mask(s);
    endfunction

    // Bytes shifted past bit 63 fall off, so a line-crossing store is truncated.
    function automatic logic [63:0] merge(input logic [63:0] line,
                                          input logic [63:0] wd,
                                          input logic [2:0] off,
                                          input logic [1:0] s);
        logic [63:0] m;
        m = size_mask(s) << {off, 3'b000};
        return (line & ~m) | ((wd << {off, 3'b000}) & m);
    endfunction

    logic [2:0]          a_off;
    logic [IDX_BITS-1:0] a_idx, cur_idx;
    logic [TAG_BITS-1:0] a_tag, m_tag;
    logic                m_valid, m_dirty, main_hit, vhit, accept;
    logic [63:0]         m_data, v_data;
    logic [VC_DEPTH-1:0] vmatch;
    logic [PW-1:0]       vsel;
    logic                fill_done, fill_ev;

    assign a_off    = req_addr[2:0];
    assign a_idx    = req_addr[IDX_BITS+2:3];
    assign a_tag    = req_addr[AW-1:IDX_BITS+3];
    assign cur_idx  = (state_q == S_IDLE) ? a_idx : r_idx_q;
    assign m_valid  = valid_q[cur_idx];
    assign m_dirty  = dirty_q[cur_idx];
    assign m_tag    = line_tag_q[cur_idx];
    assign m_data   = line_data_q[cur_idx];
    assign main_hit = m_valid && (m_tag == a_tag);
    assign accept   = req_valid && req_ready_q;
    assign v_data   = vc_data_q[vsel];
    assign vhit     = (|vmatch) && !main_hit;
    assign fill_done = (state_q == S_FILL_WAIT) && mem_rsp_valid;
    assign fill_ev  = m_valid && vc_valid_q[fifo_q] && vc_dirty_q[fifo_q];

    always_comb begin
        vmatch = '0;
        vsel   = '0;
        for (int i = 0; i < VC_DEPTH; i++) begin
            vmatch[i] = vc_valid_q[i] && (vc_line_q[i] == {a_tag, a_idx});
            if (vmatch[i]) vsel = PW'(i);
        end
    end

    logic                main_we, main_wdirty;
    logic [63:0]         main_wdata;
    logic [TAG_BITS-1:0] main_wtag;
    logic                vc_we, vc_wvalid, vc_wdirty;
    logic [PW-1:0]       vc_wsel;
    logic [LW-1:0]       vc_wline;
    logic [63:0]         vc_wdata;

    always_comb begin
        main_we     = 1'b0;
        main_wdirty = 1'b0;
        main_wdata  = '0;
        main_wtag   = '0;
        vc_we       = 1'b0;
        vc_wvalid   = 1'b0;
        vc_wdirty   = 1'b0;
        vc_wsel     = '0;
        vc_wline    = '0;
        vc_wdata    = '0;
        if (accept && main_hit && req_wr) begin
            main_we     = 1'b1;
            main_wdirty = 1'b1;
            main_wtag   = a_tag;
            main_wdata  = merge(m_data, req_wdata, a_off, req_size);
        end else if (accept && vhit) begin
            // Swap: victim entry becomes the main line, old main line takes its slot.
            main_we     = 1'b1;
            main_wdirty = vc_dirty_q[vsel] | req_wr;
            main_wtag   = vc_line_q[vsel][LW-1:IDX_BITS];
            main_wdata  = req_wr ? merge(v_data, req_wdata, a_off, req_size) : v_data;
            vc_we       = 1'b1;
            vc_wsel     = vsel;
            vc_wvalid   = m_valid;
            vc_wdirty   = m_dirty;
            vc_wline    = {m_tag, cur_idx};
            vc_wdata    = m_data;
        end else if (fill_done) begin
            main_we    = 1'b1;
            main_wtag  = r_tag_q;
            main_wdata = mem_rsp_data;
            vc_we      = m_valid;
            vc_wsel    = fifo_q;
            vc_wvalid  = 1'b1;
            vc_wdirty  = m_dirty;
            vc_wline   = {m_tag, r_idx_q};
            vc_wdata   = m_data;
        end
    end

    always_ff @(posedge clock) begin
        if (main_we) begin
            line_data_q[cur_idx] <= main_wdata;
            line_tag_q[cur_idx]  <= main_wtag;
        end
        if (vc_we) begin
            vc_data_q[vc_wsel] <= vc_wdata;
            vc_line_q[vc_wsel] <= vc_wline;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            vc_valid_q   <= '0;
            vc_dirty_q   <= '0;
            fifo_q       <= '0;
            r_idx_q      <= '0;
            r_tag_q      <= '0;
            r_off_q      <= '0;
            r_size_q     <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_gnt_q    <= '0;
            mreq_valid_q <= 1'b0;
            mreq_wr_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wdata_q <= '0;
            mreq_size_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (main_we) begin
                valid_q[cur_idx] <= 1'b1;
                dirty_q[cur_idx] <= main_wdirty;
            end
            if (vc_we) begin
                vc_valid_q[vc_wsel] <= vc_wvalid;
                vc_dirty_q[vc_wsel] <= vc_wdirty;
            end
            unique case (state_q)
                S_IDLE: if (accept) begin
                    rsp_gnt_q <= req_gnt;
                    r_idx_q   <= a_idx;
                    r_tag_q   <= a_tag;
                    r_off_q   <= a_off;
                    r_size_q  <= req_size;
                    if (main_hit || vhit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= req_wr ? 64'd0 :
                            extract(main_hit ? m_data : v_data, a_off, req_size);
                    end else begin
                        req_ready_q  <= 1'b0;
                        mreq_valid_q <= 1'b1;
                        mreq_wr_q    <= req_wr;
                        if (req_wr) begin
                            state_q      <= S_WR_FWD;
                            mreq_addr_q  <= req_addr;
                            mreq_wdata_q <= req_wdata;
                            mreq_size_q  <= req_size;
                        end else begin
                            state_q      <= S_FILL_REQ;
                            mreq_addr_q  <= {a_tag, a_idx, 3'b000};
                            mreq_wdata_q <= '0;
                            mreq_size_q  <= 2'd3;
                        end
                    end
                end
                S_WR_FWD: if (mem_req_ready) begin
                    mreq_valid_q <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= '0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_FILL_REQ: if (mem_req_ready) begin
                    mreq_valid_q <= 1'b0;
                    state_q      <= S_FILL_WAIT;
                end
                S_FILL_WAIT: if (mem_rsp_valid) begin
                    rsp_data_q <= extract(mem_rsp_data, r_off_q, r_size_q);
                    if (m_valid)
                        fifo_q <= (fifo_q == PW'(VC_DEPTH - 1)) ? '0 : fifo_q + 1'b1;
                    if (fill_ev) begin
                        mreq_valid_q <= 1'b1;
                        mreq_wr_q    <= 1'b1;
                        mreq_addr_q  <= {vc_line_q[fifo_q], 3'b000};
                        mreq_wdata_q <= vc_data_q[fifo_q];
                        mreq_size_q  <= 2'd3;
                        state_q      <= S_EVICT;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_EVICT: if (mem_req_ready) begin
                    mreq_valid_q <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_gnt       = rsp_gnt_q;
    assign mem_req_valid = mreq_valid_q;
    assign mem_req_wr    = mreq_wr_q;
    assign mem_req_addr  = mreq_addr_q;
    assign mem_req_wdata = mreq_wdata_q;
    assign mem_req_size  = mreq_size_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, vhit_q, miss_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            vhit_q <= '0;
            miss_q <= '0;
        end else if (accept) begin
            if (main_hit) begin
                if (hit_q != '1) hit_q <= hit_q + 1'b1;
            end else if (vhit) begin
                if (vhit_q != '1) vhit_q <= vhit_q + 1'b1;
            end else if (miss_q != '1) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign vhit_cnt = vhit_q;
    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_dcache_vc.sv
// Directed bench for dcache_vc: fills, hits, victim swaps, eviction,
// store forwarding, line-crossing accesses and reset during a fill.
`timescale 1ns/1ps
module tb_dcache_vc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_gnt = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [7:0]  rsp_gnt;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wr;
    logic [15:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;

    always #5 clock = ~clock;

    dcache_vc dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_gnt(rsp_gnt), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_size(mem_req_size), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: ready on first sight of a request, fill one cycle later.
    logic [63:0] fill_data = '0;
    bit          hold_rsp = 1'b0;
    int          inject_req = 0;
    int          inject_seen = 0;
    int          mem_cnt = 0;
    logic        last_wr = 1'b0;
    logic [15:0] last_addr = '0;
    logic [1:0]  last_size = '0;
    logic [63:0] last_wdata = '0;

    initial begin
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt = 0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (inject_req != inject_seen) begin
                inject_seen   = inject_req;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = fill_data;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend          = 1'b0;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = fill_data;
                end
            end else if (mem_req_valid && !reset) begin
                mem_req_ready = 1'b1;
                mem_cnt++;
                last_wr    = mem_req_wr;
                last_addr  = mem_req_addr;
                last_size  = mem_req_size;
                last_wdata = mem_req_wdata;
                if (!mem_req_wr && !hold_rsp) begin
                    pend = 1'b1;
                    cnt  = 1;
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [15:0] addr,
                          input logic [1:0] sz, input logic [63:0] wd,
                          input logic [7:0] gnt, output logic [63:0] d,
                          output logic [7:0] g, output int lat);
        int w;
        @(negedge clock);
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_size  = sz;
        req_wdata = wd;
        req_gnt   = gnt;
        lat = 0;
        do begin
            @(negedge clock);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 200);
        check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
        d = rsp_data;
        g = rsp_gnt;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  g;
        int          lat;
        int          m0;

        repeat (2) @(negedge clock);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        reset = 1'b0;

        fill_data = 64'h1122_3344_5566_7788;
        m0 = mem_cnt;
        do_req(1'b0, 16'h0100, 2'd3, '0, 8'h5A, d, g, lat);
        check("fill_data", d, 64'h1122_3344_5566_7788);
        check("fill_gnt", {56'd0, g}, 64'h5A);
        check("fill_addr", {48'd0, last_addr}, 64'h0100);
        check("fill_wr", {63'd0, last_wr}, 64'd0);
        check("fill_size", {62'd0, last_size}, 64'd3);
        check("fill_mem_cnt", 64'(mem_cnt - m0), 64'd1);
        check("miss_lat_gt1", {63'd0, lat > 1}, 64'd1);

        m0 = mem_cnt;
        do_req(1'b0, 16'h0100, 2'd3, '0, 8'h11, d, g, lat);
        check("hit_data", d, 64'h1122_3344_5566_7788);
        check("hit_gnt", {56'd0, g}, 64'h11);
        check("hit_lat", 64'(lat), 64'd1);

        do_req(1'b1, 16'h0103, 2'd0, 64'hAB, 8'h03, d, g, lat);
        check("st_hit_lat", 64'(lat), 64'd1);
        check("st_hit_data0", d, 64'd0);
        do_req(1'b0, 16'h0100, 2'd3, '0, 8'h04, d, g, lat);
        check("st_merge", d, 64'h1122_3344_AB66_7788);
        do_req(1'b0, 16'h0102, 2'd1, '0, 8'h05, d, g, lat);
        check("half_load", d, 64'hAB66);
        check("hit_no_mem", 64'(mem_cnt - m0), 64'd0);

        fill_data = 64'hA1A2_A3A4_A5A6_A7A8;
        m0 = mem_cnt;
        do_req(1'b0, 16'h2100, 2'd3, '0, 8'h06, d, g, lat);
        check("conf_data", d, 64'hA1A2_A3A4_A5A6_A7A8);
        check("conf_mem_cnt", 64'(mem_cnt - m0), 64'd1);

        m0 = mem_cnt;
        do_req(1'b0, 16'h0100, 2'd3, '0, 8'h07, d, g, lat);
        check("vhit_data", d, 64'h1122_3344_AB66_7788);
        check("vhit_lat", 64'(lat), 64'd1);
        do_req(1'b0, 16'h2100, 2'd3, '0, 8'h08, d, g, lat);
        check("vhit2_data", d, 64'hA1A2_A3A4_A5A6_A7A8);
        check("vhit2_lat", 64'(lat), 64'd1);
        check("vhit_no_mem", 64'(mem_cnt - m0), 64'd0);

        fill_data = 64'h4444_4444_4444_4444;
        m0 = mem_cnt;
        do_req(1'b0, 16'h4100, 2'd3, '0, 8'h09, d, g, lat);
        check("fill3_data", d, 64'h4444_4444_4444_4444);
        check("fill3_no_ev", 64'(mem_cnt - m0), 64'd1);
        fill_data = 64'h5555_6666_7777_8888;
        m0 = mem_cnt;
        do_req(1'b0, 16'h5100, 2'd3, '0, 8'h0A, d, g, lat);
        check("ev_rsp_data", d, 64'h5555_6666_7777_8888);
        check("ev_mem_cnt", 64'(mem_cnt - m0), 64'd2);
        check("ev_wr", {63'd0, last_wr}, 64'd1);
        check("ev_addr", {48'd0, last_addr}, 64'h0100);
        check("ev_size", {62'd0, last_size}, 64'd3);
        check("ev_wdata", last_wdata, 64'h1122_3344_AB66_7788);

        m0 = mem_cnt;
        do_req(1'b1, 16'h3008, 2'd2, 64'hDEAD_BEEF, 8'h77, d, g, lat);
        check("wf_gnt", {56'd0, g}, 64'h77);
        check("wf_rsp_data", d, 64'd0);
        check("wf_wr", {63'd0, last_wr}, 64'd1);
        check("wf_addr", {48'd0, last_addr}, 64'h3008);
        check("wf_size", {62'd0, last_size}, 64'd2);
        check("wf_wdata", last_wdata, 64'hDEAD_BEEF);
        fill_data = 64'hCAFE_BABE_1234_5678;
        do_req(1'b0, 16'h3008, 2'd2, '0, 8'h0B, d, g, lat);
        check("wf_no_alloc", 64'(mem_cnt - m0), 64'd2);
        check("wf_ld_addr", {48'd0, last_addr}, 64'h3008);
        check("wf_ld_data", d, 64'h1234_5678);

        do_req(1'b0, 16'h300F, 2'd2, '0, 8'h0C, d, g, lat);
        check("cross_load", d, 64'hCA);
        do_req(1'b1, 16'h300E, 2'd2, 64'h1122_3344, 8'h0D, d, g, lat);
        do_req(1'b0, 16'h3008, 2'd3, '0, 8'h0E, d, g, lat);
        check("cross_store", d, 64'h3344_BABE_1234_5678);

        hold_rsp = 1'b1;
        fill_data = 64'h6666_6666_6666_6666;
        @(negedge clock);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h6100;
        req_size  = 2'd3;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("fw_busy", {63'd0, req_ready}, 64'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clock);
        reset = 1'b0;
        inject_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("late_rsp_ignored", {63'd0, rsp_valid}, 64'd0);
        end
        check("post_rst_ready", {63'd0, req_ready}, 64'd1);
        hold_rsp = 1'b0;
        fill_data = 64'h0BAD_F00D_0000_0001;
        m0 = mem_cnt;
        do_req(1'b0, 16'h5100, 2'd3, '0, 8'h0F, d, g, lat);
        check("post_rst_miss", 64'(mem_cnt - m0), 64'd1);
        check("post_rst_data", d, 64'h0BAD_F00D_0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
